// File: rtl/axi_slave_wr_pkg.sv
// Shared types and constants for the AXI4 slave write responder.
package axi_slave_wr_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] SIZE_WORD   = 3'b010;

  // A burst is unserviceable unless it is word-sized, word-aligned FIXED/INCR.
  function automatic logic aw_is_bad(input logic [2:0] size,
                                     input logic [1:0] burst,
                                     input logic [1:0] addr_lsb);
    return (size != SIZE_WORD) ||
           !((burst == BURST_FIXED) || (burst == BURST_INCR)) ||
           (addr_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/axi_slave_wr_if.sv
// AW/W/B channel bundle between the interconnect slave port and the responder.
interface axi_slave_wr_if #(
  parameter int IDS_BITS  = 8,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 4
) ();
  logic [IDS_BITS-1:0]    AWID_S;
  logic [ADDR_BITS-1:0]   AWADDR_S;
  logic [LEN_BITS-1:0]    AWLEN_S;
  logic [2:0]             AWSIZE_S;
  logic [1:0]             AWBURST_S;
  logic                   AWVALID_S;
  logic                   AWREADY_S;
  logic [DATA_BITS-1:0]   WDATA_S;
  logic [DATA_BITS/8-1:0] WSTRB_S;
  logic                   WLAST_S;
  logic                   WVALID_S;
  logic                   WREADY_S;
  logic [IDS_BITS-1:0]    BID_S;
  logic [1:0]             BRESP_S;
  logic                   BVALID_S;
  logic                   BREADY_S;

  modport master (
    output AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    output WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S,
    input  AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S
  );

  modport slave (
    input  AWID_S, AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S, AWVALID_S,
    input  WDATA_S, WSTRB_S, WLAST_S, WVALID_S, BREADY_S,
    output AWREADY_S, WREADY_S, BID_S, BRESP_S, BVALID_S
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Current word address of the active burst: loaded at AW accept, stepped per beat.
module axi_burst_addr_gen
  import axi_slave_wr_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     load,
  input  logic [MEM_ADDR_BITS-1:0] start_addr,
  input  burst_t                   burst,
  input  logic                     advance,
  output logic [MEM_ADDR_BITS-1:0] addr
);

  localparam logic [MEM_ADDR_BITS-1:0] ADDR_STEP = 1;

  burst_t burst_q;

  // Load on AW accept; INCR steps one word per beat and wraps naturally, FIXED holds.
  // NOTE: registered state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr    <= '0;
      burst_q <= BURST_FIXED;
    end else if (load) begin
      addr    <= start_addr;
      burst_q <= burst;
    end else if (advance && (burst_q == BURST_INCR)) begin
      addr    <= addr + ADDR_STEP;
    end
  end

endmodule

// File: rtl/axi_slave_wr.sv
// AXI4 slave write responder: one burst at a time, each beat becomes a word write.
module axi_slave_wr
  import axi_slave_wr_pkg::*;
#(
  parameter int IDS_BITS      = 8,
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int LEN_BITS      = 4,
  parameter int MEM_ADDR_BITS = 14
) (
  input  logic                     clk,
  input  logic                     rstn,
  axi_slave_wr_if.slave            bus,
  output logic                     mem_we,
  output logic [DATA_BITS/8-1:0]   mem_wmask,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0]     mem_wdata
);

  localparam logic [LEN_BITS-1:0] COUNT_STEP = 1;

  wr_state_t           state;
  logic [LEN_BITS-1:0] count;
  logic [LEN_BITS-1:0] len_q;
  logic [IDS_BITS-1:0] id_q;
  logic                err;

  logic aw_hs;
  logic w_hs;
  logic last_beat;
  logic len_mismatch;
  logic unused_addr_bits;

  assign aw_hs        = bus.AWVALID_S & bus.AWREADY_S;
  assign w_hs         = bus.WVALID_S & bus.WREADY_S;
  assign last_beat    = bus.WLAST_S | (count == len_q);
  assign len_mismatch = bus.WLAST_S ^ (count == len_q);

  // Only the word-address window of AWADDR reaches the memory port.
  assign unused_addr_bits = &{1'b0, bus.AWADDR_S[ADDR_BITS-1:MEM_ADDR_BITS+2]};

  // Beats are written in the handshake cycle; errored bursts are drained without writing.
  assign mem_we    = w_hs & ~err;
  assign mem_wmask = mem_we ? bus.WSTRB_S : '0;
  assign mem_wdata = bus.WDATA_S;

  axi_burst_addr_gen #(
    .MEM_ADDR_BITS(MEM_ADDR_BITS)
  ) u_addr_gen (
    .clk       (clk),
    .rstn      (rstn),
    .load      (aw_hs),
    .start_addr(bus.AWADDR_S[MEM_ADDR_BITS+1:2]),
    .burst     (burst_t'(bus.AWBURST_S)),
    .advance   (w_hs),
    .addr      (mem_addr)
  );

  // Burst FSM with registered channel handshakes and response.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      count         <= '0;
      len_q         <= '0;
      id_q          <= '0;
      err           <= 1'b0;
      bus.AWREADY_S <= 1'b1;
      bus.WREADY_S  <= 1'b0;
      bus.BVALID_S  <= 1'b0;
      bus.BID_S     <= '0;
      bus.BRESP_S   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            id_q          <= bus.AWID_S;
            len_q         <= bus.AWLEN_S;
            count         <= '0;
            err           <= aw_is_bad(bus.AWSIZE_S, bus.AWBURST_S, bus.AWADDR_S[1:0]);
            bus.AWREADY_S <= 1'b0;
            bus.WREADY_S  <= 1'b1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (last_beat) begin
              err          <= err | len_mismatch;
              bus.WREADY_S <= 1'b0;
              bus.BVALID_S <= 1'b1;
              bus.BID_S    <= id_q;
              bus.BRESP_S  <= (err | len_mismatch) ? RESP_SLVERR : RESP_OKAY;
              state        <= RESP;
            end else begin
              count <= count + COUNT_STEP;
            end
          end
        end
        RESP: begin
          if (bus.BREADY_S) begin
            bus.BVALID_S  <= 1'b0;
            bus.AWREADY_S <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_wr.sv
// Directed self-checking bench for axi_slave_wr; drives and samples on the falling edge.
module tb_axi_slave_wr;

  localparam int IDS_BITS      = 8;
  localparam int ADDR_BITS     = 32;
  localparam int DATA_BITS     = 32;
  localparam int LEN_BITS      = 4;
  localparam int MEM_ADDR_BITS = 14;

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     mem_we;
  logic [3:0]               mem_wmask;
  logic [MEM_ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0]     mem_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  axi_slave_wr_if #(
    .IDS_BITS(IDS_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)
  ) bus ();

  axi_slave_wr #(
    .IDS_BITS(IDS_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .LEN_BITS(LEN_BITS), .MEM_ADDR_BITS(MEM_ADDR_BITS)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .mem_we   (mem_we),
    .mem_wmask(mem_wmask),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present an AW request at the falling edge and hold it through the accepting rising edge.
  task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int waited = 0;
    @(negedge clk);
    bus.AWID_S = id; bus.AWADDR_S = addr; bus.AWLEN_S = len;
    bus.AWSIZE_S = size; bus.AWBURST_S = burst; bus.AWVALID_S = 1'b1;
    while (bus.AWREADY_S !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL aw_timeout: AWREADY got %b want 1", bus.AWREADY_S);
    end
    @(posedge clk);
    #1 bus.AWVALID_S = 1'b0;
  endtask

  // One W cycle: drive at the falling edge, sample the memory port shortly after.
  task automatic w_cycle(input logic v, input logic [31:0] d, input logic [3:0] s, input logic l,
                         output logic we, output logic [13:0] a, output logic [31:0] wd,
                         output logic [3:0] m);
    @(negedge clk);
    bus.WVALID_S = v; bus.WDATA_S = d; bus.WSTRB_S = s; bus.WLAST_S = l;
    #1;
    we = mem_we; a = mem_addr; wd = mem_wdata; m = mem_wmask;
  endtask

  // Wait (bounded) for BVALID, capture the response, accept it, report AWREADY one cycle later.
  task automatic b_take(output logic [7:0] id, output logic [1:0] resp, output logic aw_after);
    int waited = 0;
    @(negedge clk);
    bus.WVALID_S = 1'b0;
    while (bus.BVALID_S !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL b_timeout: BVALID got %b want 1", bus.BVALID_S);
    end
    id = bus.BID_S; resp = bus.BRESP_S;
    bus.BREADY_S = 1'b1;
    @(posedge clk);
    #1 bus.BREADY_S = 1'b0;
    @(negedge clk);
    aw_after = bus.AWREADY_S;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.WVALID_S = 1'b1; bus.WSTRB_S = 4'hF; bus.WDATA_S = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S} !== 3'b100) begin
      n_bad++; $display("FAIL reset_ready: aw/w/b got %b want 100",
                        {bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S});
    end
    n_cmp++;
    if ({bus.BID_S, bus.BRESP_S} !== 10'h000) begin
      n_bad++; $display("FAIL reset_b: bid/bresp got %h want 000", {bus.BID_S, bus.BRESP_S});
    end
    n_cmp++;
    if ({mem_we, mem_wmask} !== 5'b0) begin
      n_bad++; $display("FAIL reset_mem: we/mask got %b want 00000", {mem_we, mem_wmask});
    end
    bus.WVALID_S = 1'b0; bus.WSTRB_S = 4'h0;
    rstn = 1'b1;
  endtask

  task automatic test_single();
    logic we; logic [13:0] a; logic [31:0] wd; logic [3:0] m;
    logic [7:0] id; logic [1:0] resp; logic awr;
    aw_send(8'h5A, 32'h0000_0010, 4'd0, 3'b010, 2'b01);
    w_cycle(1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, we, a, wd, m);
    n_cmp++;
    if ({we, a, wd, m} !== {1'b1, 14'h0004, 32'hDEAD_BEEF, 4'hF}) begin
      n_bad++; $display("FAIL single_beat: we=%b addr=%h data=%h mask=%h want 1 0004 deadbeef f",
                        we, a, wd, m);
    end
    w_cycle(1'b0, 32'h0, 4'h0, 1'b0, we, a, wd, m);
    n_cmp++;
    if ({bus.BVALID_S, bus.BID_S, bus.BRESP_S, bus.WREADY_S, bus.AWREADY_S, we} !==
        {1'b1, 8'h5A, 2'b00, 1'b0, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL single_b_next_cycle: bvalid=%b bid=%h bresp=%b wready=%b awready=%b we=%b want 1 5a 00 0 0 0",
                        bus.BVALID_S, bus.BID_S, bus.BRESP_S, bus.WREADY_S, bus.AWREADY_S, we);
    end
    b_take(id, resp, awr);
    n_cmp++;
    if (awr !== 1'b1) begin
      n_bad++; $display("FAIL single_aw_after_b: awready got %b want 1", awr);
    end
  endtask

  task automatic test_incr_gap();
    logic we; logic [13:0] a; logic [31:0] wd; logic [3:0] m;
    logic [7:0] id; logic [1:0] resp; logic awr;
    logic        v_tab  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic        l_tab  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [13:0] a_tab  [5] = '{14'h40, 14'h41, 14'h42, 14'h42, 14'h43};
    logic        we_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    aw_send(8'h03, 32'h0000_0100, 4'd3, 3'b010, 2'b01);
    for (int i = 0; i < 5; i++) begin
      w_cycle(v_tab[i], 32'hA000_0000 + i, 4'hF, l_tab[i], we, a, wd, m);
      n_cmp++;
      if (we !== we_tab[i] || (we_tab[i] && a !== a_tab[i])) begin
        n_bad++; $display("FAIL incr_beat%0d: we=%b addr=%h want we=%b addr=%h",
                          i, we, a, we_tab[i], a_tab[i]);
      end
    end
    b_take(id, resp, awr);
    n_cmp++;
    if ({id, resp} !== {8'h03, 2'b00}) begin
      n_bad++; $display("FAIL incr_b: bid=%h bresp=%b want 03 00", id, resp);
    end
  endtask

  task automatic test_fixed();
    logic we; logic [13:0] a; logic [31:0] wd; logic [3:0] m;
    logic [7:0] id; logic [1:0] resp; logic awr;
    logic [3:0] s_tab [3] = '{4'h3, 4'hC, 4'hF};
    aw_send(8'h11, 32'h0000_0020, 4'd2, 3'b010, 2'b00);
    for (int i = 0; i < 3; i++) begin
      w_cycle(1'b1, 32'hF000_0000 + i, s_tab[i], (i == 2), we, a, wd, m);
      n_cmp++;
      if ({we, a, m} !== {1'b1, 14'h0008, s_tab[i]}) begin
        n_bad++; $display("FAIL fixed_beat%0d: we=%b addr=%h mask=%h want 1 0008 %h",
                          i, we, a, m, s_tab[i]);
      end
    end
    b_take(id, resp, awr);
    n_cmp++;
    if ({id, resp} !== {8'h11, 2'b00}) begin
      n_bad++; $display("FAIL fixed_b: bid=%h bresp=%b want 11 00", id, resp);
    end
  endtask

  task automatic test_err_size();
    logic we; logic [13:0] a; logic [31:0] wd; logic [3:0] m;
    logic [7:0] id; logic [1:0] resp; logic awr;
    aw_send(8'h22, 32'h0000_0040, 4'd1, 3'b001, 2'b01);
    for (int i = 0; i < 2; i++) begin
      w_cycle(1'b1, 32'h5555_0000 + i, 4'hF, (i == 1), we, a, wd, m);
      n_cmp++;
      if ({we, m} !== 5'b0) begin
        n_bad++; $display("FAIL size_err_beat%0d: we=%b mask=%h want 0 0", i, we, m);
      end
    end
    b_take(id, resp, awr);
    n_cmp++;
    if ({id, resp} !== {8'h22, 2'b10}) begin
      n_bad++; $display("FAIL size_err_b: bid=%h bresp=%b want 22 10", id, resp);
    end
  endtask

  task automatic test_early_last();
    logic we; logic [13:0] a; logic [31:0] wd; logic [3:0] m;
    logic [7:0] id; logic [1:0] resp; logic awr;
    aw_send(8'h33, 32'h0000_0200, 4'd3, 3'b010, 2'b01);
    w_cycle(1'b1, 32'h1, 4'hF, 1'b0, we, a, wd, m);
    w_cycle(1'b1, 32'h2, 4'hF, 1'b1, we, a, wd, m);
    n_cmp++;
    if ({we, a} !== {1'b1, 14'h0081}) begin
      n_bad++; $display("FAIL early_last_beat1: we=%b addr=%h want 1 0081", we, a);
    end
    w_cycle(1'b1, 32'h3, 4'hF, 1'b0, we, a, wd, m);
    n_cmp++;
    if ({bus.WREADY_S, bus.BVALID_S, we} !== 3'b010) begin
      n_bad++; $display("FAIL early_last_stop: wready=%b bvalid=%b we=%b want 0 1 0",
                        bus.WREADY_S, bus.BVALID_S, we);
    end
    b_take(id, resp, awr);
    n_cmp++;
    if ({id, resp} !== {8'h33, 2'b10}) begin
      n_bad++; $display("FAIL early_last_b: bid=%h bresp=%b want 33 10", id, resp);
    end
  endtask

  task automatic test_backpressure_reset();
    logic we; logic [13:0] a; logic [31:0] wd; logic [3:0] m;
    logic [7:0] id; logic [1:0] resp; logic awr;
    aw_send(8'hC7, 32'h0000_0300, 4'd0, 3'b010, 2'b01);
    w_cycle(1'b1, 32'h77, 4'hF, 1'b1, we, a, wd, m);
    bus.BREADY_S = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.WVALID_S = 1'b0;
      n_cmp++;
      if ({bus.BVALID_S, bus.BID_S, bus.BRESP_S, bus.AWREADY_S} !== {1'b1, 8'hC7, 2'b00, 1'b0}) begin
        n_bad++; $display("FAIL bp_hold%0d: bvalid=%b bid=%h bresp=%b awready=%b want 1 c7 00 0",
                          i, bus.BVALID_S, bus.BID_S, bus.BRESP_S, bus.AWREADY_S);
      end
    end
    b_take(id, resp, awr);
    n_cmp++;
    if ({id, resp, awr} !== {8'hC7, 2'b00, 1'b1}) begin
      n_bad++; $display("FAIL bp_b: bid=%h bresp=%b awready=%b want c7 00 1", id, resp, awr);
    end
    // Abandon a burst mid-DATA with reset.
    aw_send(8'h44, 32'h0000_0400, 4'd3, 3'b010, 2'b01);
    w_cycle(1'b1, 32'h88, 4'hF, 1'b0, we, a, wd, m);
    @(negedge clk);
    bus.WVALID_S = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S} !== 3'b100) begin
      n_bad++; $display("FAIL mid_reset: aw/w/b got %b want 100",
                        {bus.AWREADY_S, bus.WREADY_S, bus.BVALID_S});
    end
    rstn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.BVALID_S !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_no_b: bvalid got %b want 0", bus.BVALID_S);
    end
  endtask

  task automatic test_wrap();
    logic we; logic [13:0] a; logic [31:0] wd; logic [3:0] m;
    logic [7:0] id; logic [1:0] resp; logic awr;
    aw_send(8'h66, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01);
    w_cycle(1'b1, 32'hAAAA_0000, 4'hF, 1'b0, we, a, wd, m);
    n_cmp++;
    if ({we, a} !== {1'b1, 14'h3FFF}) begin
      n_bad++; $display("FAIL wrap_beat0: we=%b addr=%h want 1 3fff", we, a);
    end
    w_cycle(1'b1, 32'hAAAA_0001, 4'hF, 1'b1, we, a, wd, m);
    n_cmp++;
    if ({we, a, wd} !== {1'b1, 14'h0000, 32'hAAAA_0001}) begin
      n_bad++; $display("FAIL wrap_beat1: we=%b addr=%h data=%h want 1 0000 aaaa0001", we, a, wd);
    end
    b_take(id, resp, awr);
    n_cmp++;
    if ({id, resp} !== {8'h66, 2'b00}) begin
      n_bad++; $display("FAIL wrap_b: bid=%h bresp=%b want 66 00", id, resp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.AWID_S = '0; bus.AWADDR_S = '0; bus.AWLEN_S = '0; bus.AWSIZE_S = 3'b010;
    bus.AWBURST_S = 2'b01; bus.AWVALID_S = 1'b0;
    bus.WDATA_S = '0; bus.WSTRB_S = '0; bus.WLAST_S = 1'b0; bus.WVALID_S = 1'b0;
    bus.BREADY_S = 1'b0;
    test_reset();
    test_single();
    test_incr_gap();
    test_fixed();
    test_err_size();
    test_early_last();
    test_backpressure_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_slave_wr.md
Name: axi_slave_wr

Overview:
Slave-side AXI4 write responder. It terminates the AW/W/B channels that the interconnect drives into a slave port, and converts each accepted write burst into per-beat word writes on a single-port SRAM-style port. It then returns one B response per burst. It sits between the interconnect's slave-side outputs (AWID_Sx etc.) and a memory macro wrapper, so it is the receiving end of the address/data routing done in the interconnect.

Parameters:
IDS_BITS, 8, width of extended ID (master tag + master ID) carried on AWID/BID
ADDR_BITS, 32, AXI address width
DATA_BITS, 32, AXI data width (fixed word = 4 bytes; other values unsupported)
LEN_BITS, 4, AWLEN width (max 16 beats)
MEM_ADDR_BITS, 14, word-address width of memory port

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
AWID_S  in  IDS_BITS  write address ID
AWADDR_S  in  ADDR_BITS  burst start byte address
AWLEN_S  in  LEN_BITS  beats minus one
AWSIZE_S  in  3  beat size (only 3'b010 supported)
AWBURST_S  in  2  burst type
AWVALID_S  in  1  AW valid
AWREADY_S  out  1  AW ready
WDATA_S  in  DATA_BITS  write data
WSTRB_S  in  DATA_BITS/8  byte strobes
WLAST_S  in  1  last beat marker
WVALID_S  in  1  W valid
WREADY_S  out  1  W ready
BID_S  out  IDS_BITS  response ID (= latched AWID)
BRESP_S  out  2  response code
BVALID_S  out  1  B valid
BREADY_S  in  1  B ready
mem_we  out  1  word write strobe, one cycle per beat
mem_wmask  out  DATA_BITS/8  byte enables (active-high)
mem_addr  out  MEM_ADDR_BITS  word address
mem_wdata  out  DATA_BITS  write data

Behaviour:
- Reset: rstn sampled low at posedge clk. Forces state IDLE, beat counter 0, latched ID/addr/len/err cleared. Outputs during and after reset: AWREADY_S=1, WREADY_S=0, BVALID_S=0, BID_S=0, BRESP_S=0, mem_we=0, mem_wmask=0. Reset mid-burst abandons the burst with no B response.
- FSM states: IDLE, DATA, RESP.
- IDLE: AWREADY_S=1. On AWVALID_S&AWREADY_S, latch ID, word address AWADDR_S[MEM_ADDR_BITS+1:2], len and burst, and clear the counter; go to DATA.
- Error flag set at AW accept: if AWSIZE_S!=3'b010, or AWBURST_S not FIXED(00)/INCR(01), or AWADDR_S[1:0]!=0.
- DATA: WREADY_S=1. Each W handshake is one beat.
  - mem_we=WVALID_S&WREADY_S&~err (combinational, same cycle).
  - mem_addr=current beat address; mem_wdata=WDATA_S; mem_wmask=WSTRB_S.
  - Beats with err set are consumed but not written (mem_we=0).
- Address generation: FIXED keeps the start address. INCR adds 1 word per beat, wrapping modulo 2^MEM_ADDR_BITS (no 4KB check).
- End of burst, on the handshake of beat N: if WLAST_S=1 or count==len, go to RESP.
  - Mismatch (WLAST_S=1 with count!=len, or count==len with WLAST_S=0) sets err.
  - Excess beats are not accepted because WREADY_S drops.
- RESP: BVALID_S=1, BID_S=latched ID, BRESP_S=2'b00 (OKAY) or 2'b10 (SLVERR) if err. Hold until BREADY_S; on handshake go to IDLE.
- AWREADY_S=0 outside IDLE, so there is one outstanding burst max. WREADY_S=0 outside DATA, so W arriving with AW in the same cycle waits one cycle.
- Latency:
  - AW handshake at cycle t gives earliest beat 0 at t+1.
  - Last beat at cycle u gives BVALID_S at u+1.
  - B handshake at v gives AWREADY_S at v+1.
- WVALID_S low in DATA: state, counter and address hold; mem_we=0.
- BVALID_S and BID_S/BRESP_S stay stable while BREADY_S is low.

Decomposition:
- axi_pkg gains:
  - burst_t enum (FIXED/INCR/WRAP)
  - resp constants RESP_OKAY/RESP_SLVERR
  - wr_state_t enum (IDLE/DATA/RESP)
  - SIZE_WORD constant
- One sub-module, axi_burst_addr_gen: holds the registered current word address. It loads on AW accept and advances on beat handshake per burst type, with wrap.

Test Plan:
- Single write: AWADDR=0x0000_0010, LEN=0, SIZE=2, INCR, WDATA=0xDEADBEEF, WSTRB=F, WLAST=1 -> mem_we one cycle, mem_addr=4, mem_wdata=0xDEADBEEF. BVALID next cycle, BRESP=00, BID=AWID.
- INCR burst: LEN=3 at 0x100, 4 beats with WVALID gap after beat 1 -> mem_addr 0x40,0x41,0x42,0x43, no write during gap, one B OKAY.
- FIXED burst: LEN=2 at 0x20, WSTRB=3,C,F -> three writes all at mem_addr 8 with masks 3,C,F.
- Errors:
  - AWSIZE=1 -> beats consumed, mem_we never high, BRESP=10.
  - WLAST asserted on beat 1 of LEN=3 -> burst ends after 2 beats, BRESP=10.
- Backpressure/reset: BREADY held low 5 cycles -> BVALID/BID/BRESP stable, AWREADY=0. Then rstn low mid-DATA -> next cycle AWREADY=1, WREADY=0, BVALID=0.
- Wrap: INCR LEN=1 at byte 0xFFFC with MEM_ADDR_BITS=14 -> mem_addr 0x3FFF then 0x0000.
